m_pktsink_chk: RTL and testbench

- Parametrised, checking successor to the basic MIC response sink.
- Consumes response packets (RDATA, WRACK) on a TVALID/TREADY/TDATA/TLAST stream.
- Checks framing against the header (beat count, type, source ID), keeps saturating statistics counters, raises sticky error flags, and applies selectable random backpressure.
- Used as a self-checking endpoint in interconnect and requester testbenches and FPGA soak tests.

---
 rtl/m_pktsink_chk.sv | 234 +++++++++++++++++++++++
 tb/tb_m_pktsink_chk.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_pktsink_chk.sv
`default_nettype none
// ============================================================================
// Module      : m_pktsink_chk
// Description : Checking response-packet sink. It accepts RDATA and WRACK
//               packets on a valid/ready/last stream, checks the framing
//               against the header, keeps saturating statistics counters,
//               raises sticky error flags and applies LFSR-driven random
//               backpressure.
//               Optional build macro M_PKTSINK_CHK_WATCHDOG_EN adds a DATA-state
//               watchdog that closes a stalled packet after TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module m_pktsink_chk #(
    parameter int          DATA_W     = 64,
    parameter int          THROTTLE   = 0,
    parameter logic [15:0] SEED       = 16'h1234,
    parameter int          CHECK_SRC  = 0,
    parameter logic [7:0]  EXPECT_SRC = 8'h00,
    parameter int          CNT_W      = 16,
    parameter int          TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              TVALID,
    output logic              TREADY,
    input  logic [DATA_W-1:0] TDATA,
    input  logic              TLAST,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  wrack_count,
    output logic [CNT_W-1:0]  rdata_beats,
    output logic [31:0]       last_addr,
    output logic [7:0]        last_src,
    output logic              in_pkt,
    output logic              err_len,
    output logic              err_type,
    output logic              err_src,
    output logic              err_timeout,
    output logic              err_any
);

    localparam logic [1:0] c_TYPE_RDATA = 2'b10;
    localparam logic [1:0] c_TYPE_WRACK = 2'b11;

    typedef enum logic [0:0] {
        S_HEADER = 1'b0,
        S_DATA   = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [8:0]       r_cnt, w_cnt_nxt;
    logic [8:0]       r_exp;
    logic [1:0]       r_type;
    logic [31:0]      r_last_addr;
    logic [7:0]       r_last_src;
    logic [15:0]      r_rng;
    logic [CNT_W-1:0] r_pkt, r_wrack, r_rbeats;
    logic             r_err_len, r_err_type, r_err_src, r_err_to;

    logic             w_accept;
    logic [7:0]       w_src, w_rd_len;
    logic [1:0]       w_type;
    logic             w_hdr_load, w_pkt_inc, w_wrack_inc, w_rbeat_inc;
    logic             w_set_len, w_set_type, w_set_src, w_set_to;

    assign w_accept = TVALID && TREADY;
    assign w_src    = TDATA[55:48];
    assign w_rd_len = TDATA[47:40];
    assign w_type   = TDATA[33:32];

    // Header bits with no function here, plus the rng when backpressure is off
    logic w_unused;
    assign w_unused = ^{TDATA[63:56], TDATA[39:34], TDATA[2:0], r_rng, (TIMEOUT != 0)};

    generate
        if (DATA_W > 64) begin : g_wide
            logic w_unused_hi;
            assign w_unused_hi = ^TDATA[DATA_W-1:64];
        end
    endgenerate

    // Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1); SEED must be nonzero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rng <= SEED;
        else       r_rng <= {r_rng[14:0], r_rng[15] ^ r_rng[13] ^ r_rng[12] ^ r_rng[10]};
    end

    generate
        if (THROTTLE == 0) begin : g_thr_none
            assign TREADY = 1'b1;
        end else if (THROTTLE == 1) begin : g_thr_75
            assign TREADY = r_rng[14] | r_rng[13];
        end else if (THROTTLE == 2) begin : g_thr_50
            assign TREADY = r_rng[14];
        end else begin : g_thr_25
            assign TREADY = r_rng[14] & r_rng[13];
        end
    endgenerate

`ifdef M_PKTSINK_CHK_WATCHDOG_EN
    localparam int              c_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    logic [c_WD_W-1:0] r_wd;
    logic              w_wd_hit;

    // Fires on the edge where the idle count would reach TIMEOUT
    assign w_wd_hit = (r_state == S_DATA) && !w_accept && (r_wd == c_WD_LAST);

    // Idle-cycle counter: held at zero outside DATA and cleared by every beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               r_wd <= '0;
        else if ((r_state != S_DATA) || w_accept) r_wd <= '0;
        else                                     r_wd <= r_wd + 1'b1;
    end
`endif

    // FSM state and data-beat counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_HEADER;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state decode and per-beat event strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hdr_load  = 1'b0;
        w_pkt_inc   = 1'b0;
        w_wrack_inc = 1'b0;
        w_rbeat_inc = 1'b0;
        w_set_len   = 1'b0;
        w_set_type  = 1'b0;
        w_set_src   = 1'b0;
        w_set_to    = 1'b0;
        case (r_state)
            S_HEADER: begin
                if (w_accept) begin
                    w_hdr_load = 1'b1;
                    w_cnt_nxt  = '0;
                    w_set_src  = (CHECK_SRC != 0) && (w_src != EXPECT_SRC);
                    if (TLAST) begin
                        w_pkt_inc = 1'b1;
                        case (w_type)
                            c_TYPE_WRACK: w_wrack_inc = 1'b1;
                            c_TYPE_RDATA: w_set_len   = 1'b1;
                            default:      w_set_type  = 1'b1;
                        endcase
                    end else begin
                        w_state_nxt = S_DATA;
                        w_set_type  = (w_type != c_TYPE_RDATA);
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_cnt_nxt   = (r_cnt == 9'h1FF) ? r_cnt : r_cnt + 9'd1;
                    w_rbeat_inc = (r_type == c_TYPE_RDATA);
                    if (TLAST) begin
                        w_pkt_inc   = 1'b1;
                        w_state_nxt = S_HEADER;
                        w_cnt_nxt   = '0;
                        w_set_len   = (r_type == c_TYPE_RDATA) &&
                                      (({1'b0, r_cnt} + 10'd1) != {1'b0, r_exp});
                    end
                end
`ifdef M_PKTSINK_CHK_WATCHDOG_EN
                else if (w_wd_hit) begin
                    w_set_to    = 1'b1;
                    w_pkt_inc   = 1'b1;
                    w_state_nxt = S_HEADER;
                    w_cnt_nxt   = '0;
                end
`endif
            end
            default: w_state_nxt = S_HEADER;
        endcase
    end

    // Header capture; untouched by the statistics clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_addr <= '0;
            r_last_src  <= '0;
            r_type      <= '0;
            r_exp       <= '0;
        end else if (w_hdr_load) begin
            r_last_addr <= {TDATA[31:3], 3'b000};
            r_last_src  <= w_src;
            r_type      <= w_type;
            r_exp       <= {1'b0, w_rd_len} + 9'd1;
        end
    end

    // Saturating counters and sticky flags; stat_clr wins over same-cycle events
    always_ff @(posedge clk or posedge reset) begin
        if (reset || stat_clr) begin
            r_pkt      <= '0;
            r_wrack    <= '0;
            r_rbeats   <= '0;
            r_err_len  <= 1'b0;
            r_err_type <= 1'b0;
            r_err_src  <= 1'b0;
            r_err_to   <= 1'b0;
        end else begin
            if (w_pkt_inc   && (r_pkt    != '1)) r_pkt    <= r_pkt + 1'b1;
            if (w_wrack_inc && (r_wrack  != '1)) r_wrack  <= r_wrack + 1'b1;
            if (w_rbeat_inc && (r_rbeats != '1)) r_rbeats <= r_rbeats + 1'b1;
            r_err_len  <= r_err_len  | w_set_len;
            r_err_type <= r_err_type | w_set_type;
            r_err_src  <= r_err_src  | w_set_src;
            r_err_to   <= r_err_to   | w_set_to;
        end
    end

    assign pkt_count   = r_pkt;
    assign wrack_count = r_wrack;
    assign rdata_beats = r_rbeats;
    assign last_addr   = r_last_addr;
    assign last_src    = r_last_src;
    assign in_pkt      = (r_state == S_DATA);
    assign err_len     = r_err_len;
    assign err_type    = r_err_type;
    assign err_src     = r_err_src;
    assign err_timeout = r_err_to;
    assign err_any     = r_err_len | r_err_type | r_err_src | r_err_to;

endmodule
`default_nettype wire

// File: tb/tb_m_pktsink_chk.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_pktsink_chk
// Description : Scoreboard bench for m_pktsink_chk. Three instances:
//               u_a THROTTLE=0 with source check (EXPECT_SRC=0x07, TIMEOUT=16),
//               u_b THROTTLE=2, u_c CNT_W=4. Honors M_PKTSINK_CHK_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_pktsink_chk;

    typedef struct packed {
        logic [15:0] pkt;
        logic [15:0] wrack;
        logic [15:0] rbeats;
        logic [31:0] addr;
        logic [7:0]  src;
        logic        inp;
        logic [4:0]  err;    // {any, timeout, src, type, len}
    } snap_t;

    typedef struct {
        logic [1:0] id;
        string      name;
        snap_t      s;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stat_clr = 1'b0;
    logic        tvalid [3];
    logic        tlast  [3];
    logic [63:0] tdata  [3];
    logic        tready [3];
    logic [15:0] pkt16 [2];
    logic [15:0] wr16  [2];
    logic [15:0] rb16  [2];
    logic [3:0]  c_pkt, c_wr, c_rb;
    logic [31:0] laddr [3];
    logic [7:0]  lsrc  [3];
    logic        inp [3], e_len [3], e_type [3], e_src [3], e_to [3], e_any [3];

    int    n_checks = 0;
    int    n_errors = 0;
    sb_t   sb_q [$];
    sb_t   mon_e;
    snap_t mon_o;
    logic  phase_b = 1'b0;
    int    cyc_b = 0;
    int    rdy_b = 0;

    always #5 clk = ~clk;

    m_pktsink_chk #(.THROTTLE(0), .CHECK_SRC(1), .EXPECT_SRC(8'h07), .TIMEOUT(16)) u_a (
        .clk(clk), .reset(reset), .TVALID(tvalid[0]), .TREADY(tready[0]),
        .TDATA(tdata[0]), .TLAST(tlast[0]), .stat_clr(stat_clr),
        .pkt_count(pkt16[0]), .wrack_count(wr16[0]), .rdata_beats(rb16[0]),
        .last_addr(laddr[0]), .last_src(lsrc[0]), .in_pkt(inp[0]),
        .err_len(e_len[0]), .err_type(e_type[0]), .err_src(e_src[0]),
        .err_timeout(e_to[0]), .err_any(e_any[0]));

    m_pktsink_chk #(.THROTTLE(2)) u_b (
        .clk(clk), .reset(reset), .TVALID(tvalid[1]), .TREADY(tready[1]),
        .TDATA(tdata[1]), .TLAST(tlast[1]), .stat_clr(stat_clr),
        .pkt_count(pkt16[1]), .wrack_count(wr16[1]), .rdata_beats(rb16[1]),
        .last_addr(laddr[1]), .last_src(lsrc[1]), .in_pkt(inp[1]),
        .err_len(e_len[1]), .err_type(e_type[1]), .err_src(e_src[1]),
        .err_timeout(e_to[1]), .err_any(e_any[1]));

    m_pktsink_chk #(.THROTTLE(0), .CNT_W(4)) u_c (
        .clk(clk), .reset(reset), .TVALID(tvalid[2]), .TREADY(tready[2]),
        .TDATA(tdata[2]), .TLAST(tlast[2]), .stat_clr(stat_clr),
        .pkt_count(c_pkt), .wrack_count(c_wr), .rdata_beats(c_rb),
        .last_addr(laddr[2]), .last_src(lsrc[2]), .in_pkt(inp[2]),
        .err_len(e_len[2]), .err_type(e_type[2]), .err_src(e_src[2]),
        .err_timeout(e_to[2]), .err_any(e_any[2]));

    function automatic logic [63:0] hdr(input logic [7:0] src, input logic [7:0] rdlen,
                                        input logic [1:0] typ, input logic [31:0] addr);
        return {8'h00, src, rdlen, 6'b000000, typ, addr[31:3], 3'b000};
    endfunction

    function automatic snap_t mk(input int p, input int w, input int rb, input logic [31:0] a,
                                 input logic [7:0] s, input logic i, input logic [4:0] e);
        snap_t r;
        r.pkt = 16'(p); r.wrack = 16'(w); r.rbeats = 16'(rb);
        r.addr = a; r.src = s; r.inp = i; r.err = e;
        return r;
    endfunction

    function automatic snap_t observe(input logic [1:0] id);
        snap_t r;
        if (id == 2'd2) begin
            r.pkt = {12'd0, c_pkt}; r.wrack = {12'd0, c_wr}; r.rbeats = {12'd0, c_rb};
        end else begin
            r.pkt = pkt16[id[0]]; r.wrack = wr16[id[0]]; r.rbeats = rb16[id[0]];
        end
        r.addr = laddr[id]; r.src = lsrc[id]; r.inp = inp[id];
        r.err  = {e_any[id], e_to[id], e_src[id], e_type[id], e_len[id]};
        return r;
    endfunction

    task automatic expect_snap(input logic [1:0] id, input string name, input snap_t s);
        sb_t e;
        e.id = id; e.name = name; e.s = s;
        sb_q.push_back(e);
    endtask

    // Drive one beat and hold it until the DUT takes it; returns #1 after the accepting edge
    task automatic send_beat(input logic [1:0] id, input logic [63:0] d, input logic l);
        int waits;
        waits = 0;
        @(negedge clk);
        tvalid[id] = 1'b1; tdata[id] = d; tlast[id] = l;
        while (tready[id] !== 1'b1 && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 1000) begin
            n_checks++; n_errors++;
            $display("FAIL handshake dut%0d: TREADY low for %0d cycles, required high within 1000", id, waits);
        end
        @(posedge clk); #1;
    endtask

    task automatic go_idle(input logic [1:0] id);
        tvalid[id] = 1'b0; tlast[id] = 1'b0;
    endtask

    task automatic send_data(input logic [1:0] id, input int n, input logic last_on_final);
        for (int i = 0; i < n; i++)
            send_beat(id, 64'hA5A5_0000_0000_0000 | 64'(i), last_on_final && (i == n - 1));
    endtask

    // Scoreboard monitor: compares every queued expectation against the live outputs
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_o = observe(mon_e.id);
            n_checks++;
            if (mon_o !== mon_e.s) begin
                n_errors++;
                $display("FAIL %s dut%0d: got pkt=%0d wrack=%0d rbeats=%0d addr=%h src=%h in_pkt=%b err=%b, required pkt=%0d wrack=%0d rbeats=%0d addr=%h src=%h in_pkt=%b err=%b",
                         mon_e.name, mon_e.id, mon_o.pkt, mon_o.wrack, mon_o.rbeats, mon_o.addr,
                         mon_o.src, mon_o.inp, mon_o.err, mon_e.s.pkt, mon_e.s.wrack,
                         mon_e.s.rbeats, mon_e.s.addr, mon_e.s.src, mon_e.s.inp, mon_e.s.err);
            end
        end
    end

    // Ready duty measurement for the throttled instance
    always @(posedge clk) begin
        if (phase_b) begin
            cyc_b <= cyc_b + 1;
            if (tready[1]) rdy_b <= rdy_b + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            tvalid[k] = 1'b0; tlast[k] = 1'b0; tdata[k] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) expect_snap(2'(k), "reset_state", mk(0, 0, 0, 0, 8'h00, 1'b0, 5'b00000));

        // Single-beat WRACK
        send_beat(0, hdr(8'h07, 8'd0, 2'b11, 32'h1000), 1'b1); go_idle(0);
        expect_snap(0, "wrack1", mk(1, 1, 0, 32'h1000, 8'h07, 1'b0, 5'b00000));

        // RDATA rd_len=3 with 4 data beats, in_pkt observed mid-packet
        send_beat(0, hdr(8'h07, 8'd3, 2'b10, 32'h2008), 1'b0); go_idle(0);
        expect_snap(0, "rd_hdr", mk(1, 1, 0, 32'h2008, 8'h07, 1'b1, 5'b00000));
        send_data(0, 2, 1'b0); go_idle(0);
        expect_snap(0, "rd_mid", mk(1, 1, 2, 32'h2008, 8'h07, 1'b1, 5'b00000));
        send_data(0, 2, 1'b1); go_idle(0);
        expect_snap(0, "rd4", mk(2, 1, 4, 32'h2008, 8'h07, 1'b0, 5'b00000));

        // RDATA rd_len=3 but only 3 data beats
        send_beat(0, hdr(8'h07, 8'd3, 2'b10, 32'h3000), 1'b0);
        send_data(0, 3, 1'b1); go_idle(0);
        expect_snap(0, "rd3_short", mk(3, 1, 7, 32'h3000, 8'h07, 1'b0, 5'b10001));

        // Statistics clear
        @(negedge clk); stat_clr = 1'b1;
        @(posedge clk); #1; stat_clr = 1'b0;
        expect_snap(0, "stat_clr", mk(0, 0, 0, 32'h3000, 8'h07, 1'b0, 5'b00000));

        // Single-beat request type, then a 2-beat WRACK
        send_beat(0, hdr(8'h07, 8'd0, 2'b01, 32'h4000), 1'b1);
        send_beat(0, hdr(8'h07, 8'd0, 2'b11, 32'h5000), 1'b0);
        send_data(0, 1, 1'b1); go_idle(0);
        expect_snap(0, "type_err", mk(2, 0, 0, 32'h5000, 8'h07, 1'b0, 5'b10010));

        // Source mismatch
        @(negedge clk); stat_clr = 1'b1;
        @(posedge clk); #1; stat_clr = 1'b0;
        send_beat(0, hdr(8'h09, 8'd0, 2'b11, 32'h6000), 1'b1); go_idle(0);
        expect_snap(0, "src_err", mk(1, 1, 0, 32'h6000, 8'h09, 1'b0, 5'b10100));

        // Clear coincident with an accepted WRACK: counts dropped, header still captured
        stat_clr = 1'b1;
        send_beat(0, hdr(8'h07, 8'd0, 2'b11, 32'h7000), 1'b1); go_idle(0);
        stat_clr = 1'b0;
        expect_snap(0, "clr_prio", mk(0, 0, 0, 32'h7000, 8'h07, 1'b0, 5'b00000));

        // Stalled RDATA: 20 idle cycles after the header
        send_beat(0, hdr(8'h07, 8'd7, 2'b10, 32'h8000), 1'b0); go_idle(0);
        repeat (20) @(posedge clk);
        #1;
`ifdef M_PKTSINK_CHK_WATCHDOG_EN
        expect_snap(0, "wd_fire", mk(1, 0, 0, 32'h8000, 8'h07, 1'b0, 5'b11000));
        send_beat(0, hdr(8'h07, 8'd0, 2'b11, 32'h9000), 1'b1); go_idle(0);
        expect_snap(0, "wd_next", mk(2, 1, 0, 32'h9000, 8'h07, 1'b0, 5'b11000));
`else
        expect_snap(0, "no_wd", mk(0, 0, 0, 32'h8000, 8'h07, 1'b1, 5'b00000));
        send_data(0, 8, 1'b1); go_idle(0);
        expect_snap(0, "no_wd_done", mk(1, 0, 8, 32'h8000, 8'h07, 1'b0, 5'b00000));
        send_beat(0, hdr(8'h07, 8'd0, 2'b11, 32'h9000), 1'b1); go_idle(0);
        expect_snap(0, "no_wd_next", mk(2, 1, 8, 32'h9000, 8'h07, 1'b0, 5'b00000));
`endif

        // 200 back-to-back RDATA packets under 50% backpressure
        phase_b = 1'b1;
        for (int p = 0; p < 200; p++) begin
            send_beat(1, hdr(8'h11, 8'd7, 2'b10, 32'hC000), 1'b0);
            send_data(1, 8, 1'b1);
        end
        go_idle(1);
        phase_b = 1'b0;
        expect_snap(1, "thr2_stream", mk(200, 0, 1600, 32'hC000, 8'h11, 1'b0, 5'b00000));
        @(negedge clk);
        n_checks++;
        if (cyc_b == 0 || rdy_b * 100 < cyc_b * 35 || rdy_b * 100 > cyc_b * 65) begin
            n_errors++;
            $display("FAIL thr2_duty: TREADY high %0d of %0d cycles, required 35..65 percent", rdy_b, cyc_b);
        end

        // Counter saturation with CNT_W=4
        for (int i = 0; i < 20; i++)
            send_beat(2, hdr(8'h22, 8'd0, 2'b11, 32'hD000 + 32'(i) * 32'd8), 1'b1);
        go_idle(2);
        expect_snap(2, "sat4", mk(15, 15, 0, 32'hD098, 8'h22, 1'b0, 5'b00000));

        // Asynchronous reset after 2 of 8 data beats, then a fresh WRACK
        send_beat(0, hdr(8'h07, 8'd7, 2'b10, 32'hA000), 1'b0);
        send_data(0, 2, 1'b0); go_idle(0);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        expect_snap(0, "rst_mid", mk(0, 0, 0, 32'h0, 8'h00, 1'b0, 5'b00000));
        send_beat(0, hdr(8'h07, 8'd0, 2'b11, 32'hB000), 1'b1); go_idle(0);
        expect_snap(0, "post_rst", mk(1, 1, 0, 32'hB000, 8'h07, 1'b0, 5'b00000));

        repeat (3) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
